// File: rtl/cla_nibble_seq.sv
// Sequential adder that reuses one 4-bit carry-lookahead slice across all
// nibbles of the operands, one nibble per clock, with a done pulse on completion.
module cla_nibble_seq #(
    parameter int N_NIB = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [4*N_NIB-1:0] a,
    input  logic [4*N_NIB-1:0] b,
    input  logic               ci,
    output logic               busy,
    output logic               done,
    output logic [4*N_NIB-1:0] s,
    output logic               co,
    output logic               ov
);

    localparam int W  = 4 * N_NIB;
    localparam int IW = (N_NIB > 1) ? $clog2(N_NIB) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [W-1:0]  work;
    logic [W-1:0]  work_next;

    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] sl_sum;
    logic       sl_c1;
    logic       sl_c2;
    logic       sl_c3;
    logic       sl_co;
    logic       last_nib;

    // Select the operand nibbles addressed by idx.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path through the block can infer a latch.
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < N_NIB; i++) begin
            if (idx == IW'(i)) begin
                nib_a = op_a[4*i +: 4];
                nib_b = op_b[4*i +: 4];
            end
        end
    end

    // The single carry-lookahead slice; carry-in comes only from the carry register.
    assign g = nib_a & nib_b;
    assign p = nib_a ^ nib_b;

    assign sl_c1 = g[0] | (p[0] & carry);
    assign sl_c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    assign sl_c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & carry);
    assign sl_co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & carry);

    assign sl_sum = p ^ {sl_c3, sl_c2, sl_c1, carry};

    assign last_nib = (idx == IW'(N_NIB - 1));

    // Work word with the current nibble's sum merged in; on the last nibble this
    // is the finished result.
    always_comb begin
        work_next = work;
        for (int i = 0; i < N_NIB; i++) begin
            if (idx == IW'(i)) begin
                work_next[4*i +: 4] = sl_sum;
            end
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            idx   <= '0;
            carry <= 1'b0;
            // NOTE: operand and work registers are cleared too, so an aborted addition leaves nothing stale behind.
            op_a  <= '0;
            op_b  <= '0;
            work  <= '0;
            s     <= '0;
            co    <= 1'b0;
            ov    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= ci;
                        idx   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    work  <= work_next;
                    carry <= sl_co;
                    idx   <= idx + IW'(1);
                    if (last_nib) begin
                        s     <= work_next;
                        co    <= sl_co;
                        ov    <= sl_c3 ^ sl_co;
                        idx   <= '0;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_RUN) || (state == ST_DONE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_cla_nibble_seq.sv
// Self-checking bench for cla_nibble_seq: directed table, abort/ignore
// sequences, and randomized additions checked against an arithmetic model.
module tb_cla_nibble_seq;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         co;
    logic         ov;

    int n_vec;
    int n_err;

    logic [W-1:0] last_s;
    logic         last_co;
    logic         last_ov;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs [6];

    cla_nibble_seq #(.N_NIB(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .ci      (ci),
        .busy    (busy),
        .done    (done),
        .s       (s),
        .co      (co),
        .ov      (ov)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain W+1 bit addition and the sign rule for overflow.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mci,
                         output logic [W-1:0] ms, output logic mco, output logic mov);
        logic [W:0] full;
        full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mci};
        ms   = full[W-1:0];
        mco  = full[W];
        mov  = (ma[W-1] == mb[W-1]) && (ms[W-1] != ma[W-1]);
    endtask

    // Entered at a negedge with the DUT in IDLE or DONE; leaves at the negedge where done is high.
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_ci,
                          input logic [W-1:0] es, input logic eco, input logic eov,
                          input string name);
        int   edges;
        int   lat;
        logic from_done;
        from_done = done;
        a     = op_a;
        b     = op_b;
        ci    = op_ci;
        start = 1'b1;
        edges = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end while (!(busy && !done) && edges < 8);
        start = 1'b0;
        check({name, ":accept_edges"}, 64'(edges), from_done ? 64'd2 : 64'd1);
        lat = 0;
        while (!done && lat < 20) begin
            check({name, ":hold"}, {s, co, ov}, {last_s, last_co, last_ov});
            @(negedge clk);
            lat++;
        end
        check({name, ":latency"}, 64'(lat), 64'(N));
        check({name, ":busy"}, 64'(busy), 64'd1);
        check({name, ":s"}, 64'(s), 64'(es));
        check({name, ":co"}, 64'(co), 64'(eco));
        check({name, ":ov"}, 64'(ov), 64'(eov));
        last_s  = es;
        last_co = eco;
        last_ov = eov;
    endtask

    // Idle cycles after a completion; the first one also confirms done lasted one cycle.
    task automatic idle_gap(input int n, input string name);
        if (n > 0) begin
            @(negedge clk);
            check({name, ":done_width"}, {62'd0, done, busy}, 64'd0);
            repeat (n - 1) @(negedge clk);
        end
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rci;
        logic [W-1:0] rs;
        logic         rco;
        logic         rov;
        int           gap;
        int           dcount;

        n_vec   = 0;
        n_err   = 0;
        last_s  = '0;
        last_co = 1'b0;
        last_ov = 1'b0;

        vecs[0] = '{a: 16'h1234, b: 16'h4321, ci: 1'b0, s: 16'h5555, co: 1'b0, ov: 1'b0};
        vecs[1] = '{a: 16'hFFFF, b: 16'h0001, ci: 1'b0, s: 16'h0000, co: 1'b1, ov: 1'b0};
        vecs[2] = '{a: 16'h7FFF, b: 16'h0001, ci: 1'b0, s: 16'h8000, co: 1'b0, ov: 1'b1};
        vecs[3] = '{a: 16'h0000, b: 16'h0000, ci: 1'b1, s: 16'h0001, co: 1'b0, ov: 1'b0};
        vecs[4] = '{a: 16'h8000, b: 16'h8000, ci: 1'b0, s: 16'h0000, co: 1'b1, ov: 1'b1};
        vecs[5] = '{a: 16'hFFFF, b: 16'hFFFF, ci: 1'b1, s: 16'hFFFF, co: 1'b1, ov: 1'b0};

        reset_n = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        ci      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset:outputs", {s, co, ov, busy, done}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset:idle", {62'd0, busy, done}, 64'd0);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s, vecs[i].co, vecs[i].ov,
                   $sformatf("vec%0d", i));
            idle_gap(2, $sformatf("vec%0d", i));
        end

        // Second start pulsed with new operands while RUN must be ignored.
        a     = 16'h0F0F;
        b     = 16'h0101;
        ci    = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ignore:accept", 64'(busy), 64'd1);
        a     = 16'hAAAA;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        a      = '0;
        dcount = 0;
        for (int t = 0; t < 12; t++) begin
            if (done) begin
                dcount++;
                if (dcount == 1) begin
                    check("ignore:s", 64'(s), 64'h1010);
                    check("ignore:co_ov", {62'd0, co, ov}, 64'd0);
                end
            end
            @(negedge clk);
        end
        check("ignore:done_count", 64'(dcount), 64'd1);
        check("ignore:s_held", 64'(s), 64'h1010);
        last_s  = 16'h1010;
        last_co = 1'b0;
        last_ov = 1'b0;

        // Reset during the second RUN cycle aborts the addition.
        a     = 16'h8000;
        b     = 16'h8000;
        ci    = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("abort:running", 64'(busy), 64'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort:cleared", {s, co, ov, busy, done}, 64'd0);
        repeat (2) @(negedge clk);
        check("abort:held", {s, co, ov, busy, done}, 64'd0);
        reset_n = 1'b1;
        dcount  = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        check("abort:no_done", 64'(dcount), 64'd0);
        last_s  = '0;
        last_co = 1'b0;
        last_ov = 1'b0;
        run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "abort_retry");
        idle_gap(1, "abort_retry");

        // Random operands and gaps; gap 0 holds start high straight through DONE.
        for (int i = 0; i < 1000; i++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rci = 1'($urandom);
            if (i % 10 == 0) rb = ~ra;
            model(ra, rb, rci, rs, rco, rov);
            run_op(ra, rb, rci, rs, rco, rov, $sformatf("rnd%0d", i));
            gap = $urandom_range(0, 3);
            idle_gap(gap, $sformatf("rnd%0d", i));
        end
        idle_gap(2, "final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
